// File: rtl/hash_verifier_pkg.sv
// Shared definitions for the hash verifier: widths, FSM states and the hash
// chain step used by both the RTL and its reference model.
package hash_verifier_pkg;

  localparam int HASH_W = 16;
  localparam int TIME_W = 16;
  localparam int ID_W   = 16;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    REPORT,
    LOCKED
  } state_t;

  // One step of the chain: square the 32-bit difference and keep the middle bits.
  function automatic logic [HASH_W-1:0] hash_step(
    input logic [HASH_W-1:0] h,
    input logic [TIME_W-1:0] cur_time,
    input logic [ID_W-1:0]   id
  );
    logic [31:0] x;
    logic [31:0] d;
    logic [31:0] s;
    x = {16'h0000, cur_time ^ id};
    d = x - {16'h0000, h};
    s = d * d;
    return s[23:8];
  endfunction

endpackage

// File: rtl/hash_verifier_chain.sv
// Free-running hash chain plus a shift register of recent hashes, each tagged
// with a valid bit so never-filled slots cannot match.
module hash_chain
  import hash_verifier_pkg::*;
#(
  parameter int WINDOW = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [TIME_W-1:0]              cur_time,
  input  logic [ID_W-1:0]                student_id,
  output logic [HASH_W-1:0]              h,
  output logic [WINDOW-1:0][HASH_W-1:0]  hist,
  output logic [WINDOW-1:0]              hist_vld
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h <= '0;
    end else begin
      h <= hash_step(h, cur_time, student_id);
    end
  end

  assign hist[0]     = h;
  assign hist_vld[0] = 1'b1;

  if (WINDOW > 1) begin : g_shift
    logic [WINDOW-1:1][HASH_W-1:0] sr;
    logic [WINDOW-1:1]             sr_vld;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sr     <= '0;
        sr_vld <= '0;
      end else begin
        sr[1]     <= h;
        sr_vld[1] <= 1'b1;
        for (int k = 2; k < WINDOW; k++) begin
          sr[k]     <= sr[k-1];
          sr_vld[k] <= sr_vld[k-1];
        end
      end
    end

    assign hist[WINDOW-1:1]     = sr;
    assign hist_vld[WINDOW-1:1] = sr_vld;
  end

endmodule

// File: rtl/hash_verifier.sv
// Lock-side verifier: accepts user codes, searches a snapshot of recent hashes
// oldest-last, reports grant/deny and enforces a lockout after repeated denials.
module hash_verifier
  import hash_verifier_pkg::*;
#(
  parameter int WINDOW      = 4,
  parameter int MAX_FAILS   = 3,
  parameter int LOCK_CYCLES = 16,
  parameter int AW          = (WINDOW > 1) ? $clog2(WINDOW) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [TIME_W-1:0] cur_time,
  input  logic [ID_W-1:0]   student_id,
  input  logic [HASH_W-1:0] code,
  input  logic              code_valid,
  output logic              code_ready,
  output logic              done,
  output logic              granted,
  output logic              denied,
  output logic [AW-1:0]     match_age,
  output logic              locked,
  output logic [HASH_W-1:0] exp_hash
);

  localparam int FW = $clog2(MAX_FAILS + 1);
  localparam int LW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  logic [WINDOW-1:0][HASH_W-1:0] hist;
  logic [WINDOW-1:0]             hist_vld;

  state_t                        state;
  logic [HASH_W-1:0]             code_q;
  logic [WINDOW-1:0][HASH_W-1:0] snap;
  logic [WINDOW-1:0]             snap_vld;
  logic [AW-1:0]                 idx;
  logic [FW-1:0]                 fail_cnt;
  logic [LW-1:0]                 lock_cnt;

  hash_chain #(.WINDOW(WINDOW)) u_chain (
    .clk       (clk),
    .rst_n     (rst_n),
    .cur_time  (cur_time),
    .student_id(student_id),
    .h         (exp_hash),
    .hist      (hist),
    .hist_vld  (hist_vld)
  );

  // Result flags are loaded on entry to REPORT, so REPORT can act on them directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      code_ready <= 1'b1;
      done       <= 1'b0;
      granted    <= 1'b0;
      denied     <= 1'b0;
      match_age  <= '0;
      locked     <= 1'b0;
      code_q     <= '0;
      snap       <= '0;
      snap_vld   <= '0;
      idx        <= '0;
      fail_cnt   <= '0;
      lock_cnt   <= '0;
    end else begin
      done      <= 1'b0;
      granted   <= 1'b0;
      denied    <= 1'b0;
      match_age <= '0;
      case (state)
        IDLE: begin
          if (code_valid && code_ready) begin
            code_q     <= code;
            snap       <= hist;
            snap_vld   <= hist_vld;
            idx        <= '0;
            code_ready <= 1'b0;
            state      <= CHECK;
          end
        end
        CHECK: begin
          if (snap_vld[idx] && (snap[idx] == code_q)) begin
            done      <= 1'b1;
            granted   <= 1'b1;
            match_age <= idx;
            state     <= REPORT;
          end else if (idx == AW'(WINDOW - 1)) begin
            done   <= 1'b1;
            denied <= 1'b1;
            state  <= REPORT;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        REPORT: begin
          if (granted) begin
            fail_cnt   <= '0;
            code_ready <= 1'b1;
            state      <= IDLE;
          end else if (fail_cnt >= FW'(MAX_FAILS - 1)) begin
            fail_cnt <= FW'(MAX_FAILS);
            lock_cnt <= LW'(LOCK_CYCLES - 1);
            locked   <= 1'b1;
            state    <= LOCKED;
          end else begin
            fail_cnt   <= fail_cnt + 1'b1;
            code_ready <= 1'b1;
            state      <= IDLE;
          end
        end
        LOCKED: begin
          if (lock_cnt == '0) begin
            fail_cnt   <= '0;
            locked     <= 1'b0;
            code_ready <= 1'b1;
            state      <= IDLE;
          end else begin
            lock_cnt <= lock_cnt - 1'b1;
          end
        end
        default: begin
          code_ready <= 1'b1;
          locked     <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hash_verifier.sv
// Scoreboard bench for hash_verifier: stimulus pushes hand-computed expected
// results, a negedge monitor pops and compares on every done pulse.
module tb_hash_verifier;
  import hash_verifier_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cur_time = '0;
  logic [15:0] student_id = '0;
  logic [15:0] code = '0;
  logic        code_valid = 1'b0;
  logic        code_ready;
  logic        done;
  logic        granted;
  logic        denied;
  logic [1:0]  match_age;
  logic        locked;
  logic [15:0] exp_hash;

  typedef struct {
    logic grant;
    int   age;
    int   done_cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  hash_verifier #(.WINDOW(4), .MAX_FAILS(3), .LOCK_CYCLES(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cur_time  (cur_time),
    .student_id(student_id),
    .code      (code),
    .code_valid(code_valid),
    .code_ready(code_ready),
    .done      (done),
    .granted   (granted),
    .denied    (denied),
    .match_age (match_age),
    .locked    (locked),
    .exp_hash  (exp_hash)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must correspond to the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("granted", {31'd0, granted}, {31'd0, e.grant});
        checkOutput("denied", {31'd0, denied}, {31'd0, !e.grant});
        checkOutput("match_age", {30'd0, match_age}, e.grant ? e.age : 0);
        checkOutput("done_cycle", cyc, e.done_cyc);
      end
    end
  end

  task automatic doReset(input logic [15:0] t, input logic [15:0] id);
    @(negedge clk);
    rst_n      = 1'b0;
    code_valid = 1'b0;
    code       = '0;
    cur_time   = t;
    student_id = id;
    sb.delete();
    @(negedge clk);
    checkOutput("rst_code_ready", {31'd0, code_ready}, 32'd1);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_granted", {31'd0, granted}, 32'd0);
    checkOutput("rst_denied", {31'd0, denied}, 32'd0);
    checkOutput("rst_match_age", {30'd0, match_age}, 32'd0);
    checkOutput("rst_locked", {31'd0, locked}, 32'd0);
    checkOutput("rst_exp_hash", {16'd0, exp_hash}, 32'd0);
    rst_n = 1'b1;
  endtask

  // Hold the code until accepted; expected done cycle = accept cycle + 2 + k.
  task automatic applyStimulus(input logic [15:0] c, input logic g, input int age, input int k);
    exp_t e;
    bit   ok = 1'b0;
    code       = c;
    code_valid = 1'b1;
    for (int i = 0; i < 60 && !ok; i++) begin
      if (code_ready) begin
        e.grant    = g;
        e.age      = age;
        e.done_cyc = cyc + 2 + k;
        sb.push_back(e);
        @(posedge clk);
        #1;
        code_valid = 1'b0;
        ok = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!ok) begin
      checkOutput("accept_timeout", 32'd0, 32'd1);
      code_valid = 1'b0;
    end
  endtask

  task automatic waitDone();
    bit ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0) ok = 1'b1;
    end
    if (!ok) begin
      checkOutput("done_timeout", 32'd0, 32'd1);
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [15:0] chain_exp [5];
    int          bad;
    chain_exp[0] = 16'h0000;
    chain_exp[1] = 16'h4B5A;
    chain_exp[2] = 16'hC1F1;
    chain_exp[3] = 16'hA3F1;
    chain_exp[4] = 16'hF7A5;

    // Chain values, then a code exactly WINDOW cycles old is stale.
    doReset(16'h1234, 16'h0000);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      checkOutput($sformatf("chain_h%0d", i), {16'd0, exp_hash}, {16'd0, chain_exp[i]});
    end
    applyStimulus(16'h0000, 1'b0, 0, 3);
    waitDone();
    @(negedge clk);
    checkOutput("stale_fail_cnt", 32'(dut.fail_cnt), 32'd1);

    // Alternating chain: newest duplicate 0x0000 sits at age 1.
    doReset(16'h0000, 16'h0100);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      checkOutput($sformatf("alt_h%0d", i), {16'd0, exp_hash}, (i % 2 == 1) ? 32'h0100 : 32'h0000);
    end
    applyStimulus(16'h0000, 1'b1, 1, 1);
    waitDone();

    // Right after reset only hist[0] is valid.
    doReset(16'h1234, 16'h0000);
    applyStimulus(16'h0000, 1'b1, 0, 0);
    waitDone();
    doReset(16'h1234, 16'h0000);
    applyStimulus(16'h4B5A, 1'b0, 0, 3);
    waitDone();

    // Three wrong codes lock out for 16 cycles; a held code waits it out.
    doReset(16'h0100, 16'h0000);
    for (int n = 0; n < 3; n++) begin
      applyStimulus(16'hFFFF, 1'b0, 0, 3);
      waitDone();
    end
    code       = 16'hFFFF;
    code_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      #1;
      if (!(locked === 1'b1 && code_ready === 1'b0)) bad++;
    end
    checkOutput("lock_window_violations", bad, 32'd0);
    @(negedge clk);
    #1;
    checkOutput("unlock_locked", {31'd0, locked}, 32'd0);
    checkOutput("unlock_code_ready", {31'd0, code_ready}, 32'd1);
    checkOutput("unlock_fail_cnt", 32'(dut.fail_cnt), 32'd0);
    applyStimulus(16'hFFFF, 1'b0, 0, 3);
    waitDone();
    @(negedge clk);
    checkOutput("post_lock_fail_cnt", 32'(dut.fail_cnt), 32'd1);

    // Reset during CHECK aborts without a done pulse.
    doReset(16'h0100, 16'h0000);
    repeat (3) @(negedge clk);
    applyStimulus(16'hFFFF, 1'b0, 0, 3);
    @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    #1;
    checkOutput("abort_done", {31'd0, done}, 32'd0);
    checkOutput("abort_code_ready", {31'd0, code_ready}, 32'd1);
    checkOutput("abort_exp_hash", {16'd0, exp_hash}, 32'd0);
    checkOutput("abort_hist_vld", {28'd0, dut.hist_vld}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    checkOutput("abort_idle_ready", {31'd0, code_ready}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hash_verifier.md
Name: hash_verifier

Overview:
- Server/lock-side counterpart of the key-fob hash generator.
- Runs the same per-clock hash chain from cur_time and student_id, so its chain stays in lockstep with the fob's displayed code.
- Keeps a short history of recent hashes and accepts user-entered codes over a valid/ready handshake.
- Reports grant/deny for each code and enforces a lockout after repeated failures.

Parameters:
- WINDOW, 4: number of most recent hashes a code may match (current plus WINDOW-1 older); must be at least 1.
- MAX_FAILS, 3: consecutive denials that trigger lockout; must be at least 1.
- LOCK_CYCLES, 16: clock cycles spent in lockout; must be at least 1.
- AW, $clog2(WINDOW) (minimum 1): width of match_age.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cur_time  in  16  time value, the same one fed to the fob.
- student_id  in  16  enrolled ID, the same one programmed into the fob.
- code  in  16  user-entered candidate code.
- code_valid  in  1  code is presented.
- code_ready  out  1  verifier can accept a code.
- done  out  1  one-cycle pulse; the result outputs are valid in this cycle.
- granted  out  1  with done: code matched.
- denied  out  1  with done: code did not match.
- match_age  out  AW  with granted: how many cycles old the matching hash was (0 = current).
- locked  out  1  lockout is active.
- exp_hash  out  16  current chain hash (debug/observation).

Behaviour:
- Hash chain: register h (16 bits), reset value 0, updated every clock in every state:
  - x = cur_time ^ student_id, zero-extended to 32 bits.
  - d = (x - h) mod 2^32.
  - s = (d*d) mod 2^32.
  - h <= s[23:8].
  - exp_hash = h.
- History:
  - hist[0] is h itself.
  - hist[1..WINDOW-1] form a shift register: hist[k] <= hist[k-1] each cycle.
  - Each entry carries a valid bit, cleared by reset, so entries never yet filled can never match.
- FSM has four states: IDLE, CHECK, REPORT, LOCKED. Reset state is IDLE.
  - Reset values of outputs: code_ready=1, done=0, granted=0, denied=0, match_age=0, locked=0, fail_cnt=0.
- IDLE:
  - code_ready=1.
  - On code_valid && code_ready: latch code, snapshot hist[0..WINDOW-1] and their valid bits, set idx=0, go to CHECK.
- CHECK:
  - code_ready=0.
  - Each cycle compare the latched code against snap[idx], qualified by its valid bit.
  - On a match: record age=idx, go to REPORT with result grant.
  - On a miss with idx=WINDOW-1: go to REPORT with result deny.
  - Otherwise idx++.
  - The live chain keeps advancing; only the snapshot is compared.
- REPORT:
  - One cycle with done=1 and exactly one of granted/denied set; match_age is valid on grant and 0 on deny.
  - Grant: fail_cnt <= 0, next state IDLE.
  - Deny: fail_cnt++. If the new count equals MAX_FAILS, go to LOCKED with lock counter = LOCK_CYCLES-1; otherwise go to IDLE.
- Latency: accept at cycle T; done at cycle T+2+k, where k = matching index, or WINDOW-1 on deny.
- LOCKED:
  - locked=1, code_ready=0, and code_valid is ignored.
  - Lock counter decrements each cycle; when it reaches 0, clear fail_cnt and go to IDLE next cycle.
  - Lockout duration is therefore exactly LOCK_CYCLES cycles.
- Boundary conditions:
  - A code arriving while code_ready=0 is not consumed; the source holds it until accepted.
  - A code equal to a duplicate history entry reports the smallest age.
  - fail_cnt saturates at MAX_FAILS.
  - Asserting rst_n=0 at any time, including mid-CHECK or mid-LOCKED, immediately restores all reset values and aborts without a done pulse.

Decomposition:
- Package hash_verifier_pkg holds:
  - HASH_W=16, TIME_W=16, ID_W=16;
  - the FSM state enum (IDLE, CHECK, REPORT, LOCKED);
  - a function hash_step(h, time, id) implementing the chain equation, shared with the bench's reference model.
- One natural sub-module, hash_chain: the h register plus the shifting history with valid bits.
- The FSM, snapshot and counters live in hash_verifier.

Test Plan:
- Chain check: reset, then hold cur_time=0x1234 and student_id=0x0000 -> exp_hash reads 0x0000, then 0x4B5A, then 0xC1F1 on successive cycles.
- Alternation check: reset, then hold cur_time^student_id=0x0100 -> exp_hash alternates 0x0100, 0x0000, 0x0100, ... Submit code=0x0000 three cycles later -> granted, with match_age being the age of the newest 0x0000 entry.
- Invalid-entry check: immediately after reset (only hist[0]=0x0000 valid), submit code=0x0000 -> granted, match_age=0. Submit 0x4B5A before it has entered the history -> denied after WINDOW compare cycles.
- Stale code: submit a hash that is WINDOW cycles old -> denied, done arrives exactly WINDOW+1 cycles after accept, fail_cnt=1.
- Lockout: three consecutive wrong codes (0xFFFF) -> third REPORT is followed by locked=1 and code_ready=0 for exactly 16 cycles, a code_valid during lockout is not accepted, then code_ready=1 with fail_cnt cleared.
- Reset mid-CHECK: pull rst_n low one cycle after accept -> no done pulse, code_ready=1, exp_hash=0, and all history valid bits cleared except hist[0].
